gshare_multislot_bp: RTL

- Parametrised successor of the core's single-slot gshare predictor.
- Predicts up to FETCH_W conditional branches per fetch group using a global-history-XOR-PC indexed pattern history table (PHT) of 2-bit saturating counters.
- Keeps a speculatively updated global history register (GHR), hands each predicted slot its history checkpoint, and restores history from EX on mispredict.
- Sits in the Fetch stage beside the branch address calculator; receives resolution feedback from the branch-pipeline ALU in EX.

---
 rtl/gshare_multislot_bp.sv | 119 +++++++++++
 1 files changed

// File: rtl/gshare_multislot_bp.sv
// Multi-slot gshare branch predictor: per-slot PHT lookup under speculative history,
// checkpointed history per slot, EX-side training and mispredict recovery.
module gshare_multislot_bp #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FETCH_W   = 2,
    parameter int unsigned GHR_BITS  = 8,
    parameter int unsigned PHT_DEPTH = 256,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             pred_pc,
    input  logic [FETCH_W-1:0]           pred_valid,
    input  logic                         stall,
    output logic [FETCH_W-1:0]           pred_taken,
    output logic [FETCH_W*GHR_BITS-1:0]  pred_ghr,
    input  logic                         upd_valid,
    input  logic [WIDTH-1:0]             upd_pc,
    input  logic [GHR_BITS-1:0]          upd_ghr,
    input  logic                         upd_taken,
    input  logic                         upd_mispredict,
    output logic [CNT_W-1:0]             mispredict_cnt
);

    localparam int unsigned IDX_BITS = $clog2(PHT_DEPTH);

    logic [1:0]          pht_q [PHT_DEPTH];
    logic [GHR_BITS-1:0] ghr_q, ghr_d, ghr_fetch;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          upd_ctr, upd_ctr_next;
    logic                upd_mis_valid;

    // History is zero-extended or truncated to the index width.
    function automatic logic [IDX_BITS-1:0] fit_hist(input logic [GHR_BITS-1:0] h);
        logic [IDX_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < IDX_BITS; b++) begin
            if (b < GHR_BITS) r[b] = h[b];
        end
        return r;
    endfunction

    always_comb begin
        logic [GHR_BITS-1:0] h;
        logic [IDX_BITS+1:0] pc_lo;
        logic [IDX_BITS-1:0] idx;
        logic                seen;
        logic                done;
        pred_taken = '0;
        pred_ghr   = '0;
        h          = ghr_q;
        seen       = 1'b0;
        done       = 1'b0;
        ghr_fetch  = ghr_q;
        for (int i = 0; i < FETCH_W; i++) begin
            pred_ghr[i*GHR_BITS +: GHR_BITS] = h;
            pc_lo = pred_pc[IDX_BITS+1:0] + (IDX_BITS+2)'(4 * i);
            idx   = pc_lo[IDX_BITS+1:2] ^ fit_hist(h);
            if (pred_valid[i] && pht_q[idx][1] && !seen) begin
                pred_taken[i] = 1'b1;
                seen          = 1'b1;
            end
            if (pred_valid[i] && !pred_taken[i]) h = {h[GHR_BITS-2:0], 1'b0};
            // Committed fetch history stops after the first taken slot.
            if (pred_valid[i] && !done) begin
                ghr_fetch = {ghr_fetch[GHR_BITS-2:0], pred_taken[i]};
                done      = pred_taken[i];
            end
        end
    end

    assign upd_mis_valid = upd_valid & upd_mispredict;
    assign upd_idx       = upd_pc[IDX_BITS+1:2] ^ fit_hist(upd_ghr);
    assign upd_ctr       = pht_q[upd_idx];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken && upd_ctr != 2'b11) begin
            upd_ctr_next = upd_ctr + 2'b01;
        end else if (!upd_taken && upd_ctr != 2'b00) begin
            upd_ctr_next = upd_ctr - 2'b01;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (upd_mis_valid) begin
            ghr_d = {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (!stall) begin
            ghr_d = ghr_fetch;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_mis_valid && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
            cnt_q <= '0;
            for (int e = 0; e < PHT_DEPTH; e++) pht_q[e] <= CTR_INIT;
        end else begin
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
            if (upd_valid) pht_q[upd_idx] <= upd_ctr_next;
        end
    end

    assign mispredict_cnt = cnt_q;

    logic unused_bits;
    assign unused_bits = ^{pred_pc[WIDTH-1:IDX_BITS+2], upd_pc[WIDTH-1:IDX_BITS+2],
                           upd_pc[1:0], upd_ghr};

endmodule
